// File: rtl/seq_shiftadd_mult.sv
// ---------------------------------------------------------------------------
// seq_shiftadd_mult
//
// Iterative shift-add multiplier. Each BUSY cycle consumes BITS_PER_CYCLE
// multiplier bits, LSB first, and adds the matching shifted copies of the
// multiplicand into an accumulator. Operands may be unsigned or two's
// complement. In halved-precision mode the operands are treated as two
// packed WIDTH/2-bit lanes that are multiplied independently, with each
// lane's result occupying its own WIDTH-bit field of the product.
//
// Ports
//   clk              in   clock, all state changes on the rising edge
//   rst              in   synchronous active-high reset
//   in_valid         in   operands and mode bits are valid
//   in_ready         out  block is idle and can accept a job
//   multiplicand     in   [WIDTH-1:0] operand A
//   multiplier       in   [WIDTH-1:0] operand B (the scanned operand)
//   signed_mode      in   1 = two's-complement operands, 0 = unsigned
//   halved_precision in   1 = two packed WIDTH/2 x WIDTH/2 lanes
//   out_valid        out  product is valid and held until out_ready
//   out_ready        in   consumer accepts the product
//   product          out  [2*WIDTH-1:0] registered result
//
// Latency from accept edge to out_valid: WIDTH/BITS_PER_CYCLE cycles in
// full mode, WIDTH/(2*BITS_PER_CYCLE) in halved mode.
// ---------------------------------------------------------------------------
module seq_shiftadd_mult #(
    parameter int WIDTH          = 8,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    input  logic                 signed_mode,
    input  logic                 halved_precision,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product
);

    localparam int HALF      = WIDTH / 2;
    localparam int ITER_FULL = WIDTH / BITS_PER_CYCLE;
    localparam int ITER_HALF = HALF / BITS_PER_CYCLE;
    localparam int CNT_W     = $clog2(ITER_FULL);

    localparam logic [CNT_W-1:0] LAST_FULL = CNT_W'(ITER_FULL - 1);
    localparam logic [CNT_W-1:0] LAST_HALF = CNT_W'(ITER_HALF - 1);

    // Both lanes must finish in a whole number of iterations, which also
    // guarantees the full-width scan does.
    if ((WIDTH < 4) || ((WIDTH % 2) != 0) || (BITS_PER_CYCLE < 1) ||
        ((HALF % BITS_PER_CYCLE) != 0)) begin : gBadParams
        $error("seq_shiftadd_mult: WIDTH must be even and >= 4, BITS_PER_CYCLE must divide WIDTH/2");
    end

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } stateT;

    // Extend an operand to the full accumulator width.
    function automatic logic [2*WIDTH-1:0] extendFull(input logic [WIDTH-1:0] a,
                                                      input logic             isSigned);
        extendFull = {{WIDTH{isSigned & a[WIDTH-1]}}, a};
    endfunction

    // Extend a half-width lane operand to its WIDTH-bit lane accumulator.
    function automatic logic [WIDTH-1:0] extendLane(input logic [HALF-1:0] a,
                                                    input logic            isSigned);
        extendLane = {{HALF{isSigned & a[HALF-1]}}, a};
    endfunction

    stateT              state;
    logic [CNT_W-1:0]   count;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] accNext;

    // Latched job. mcand holds the extended multiplicand, pre-shifted by the
    // bits already consumed; in halved mode each lane shifts within its own
    // WIDTH-bit field. mplier shifts right so the bits due this iteration
    // always sit at [BITS_PER_CYCLE-1:0] (lane lo) and [HALF +: BITS_PER_CYCLE]
    // (lane hi).
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic               signedReg;
    logic               halvedReg;

    logic               lastIter;
    logic               negTerm;
    logic [2*WIDTH-1:0] accFull;
    logic [WIDTH-1:0]   accLo;
    logic [WIDTH-1:0]   accHi;

    assign in_ready = (state == IDLE) && !rst;

    // One iteration of the shift-add. Full and lane sums are formed side by
    // side; the lane sums are separate WIDTH-bit additions, so no carry or
    // borrow can cross between lanes.
    always_comb begin
        lastIter = (count == (halvedReg ? LAST_HALF : LAST_FULL));
        negTerm  = 1'b0;
        accFull  = acc;
        accLo    = acc[WIDTH-1:0];
        accHi    = acc[2*WIDTH-1:WIDTH];
        for (int j = 0; j < BITS_PER_CYCLE; j++) begin
            // The top bit of the final iteration is the operand MSB, which has
            // negative weight in two's complement.
            negTerm = signedReg && lastIter && (j == BITS_PER_CYCLE - 1);
            if (mplier[j]) begin
                accFull = negTerm ? (accFull - (mcand << j)) : (accFull + (mcand << j));
                accLo   = negTerm ? (accLo - (mcand[WIDTH-1:0] << j))
                                  : (accLo + (mcand[WIDTH-1:0] << j));
            end
            if (mplier[HALF + j]) begin
                accHi = negTerm ? (accHi - (mcand[2*WIDTH-1:WIDTH] << j))
                                : (accHi + (mcand[2*WIDTH-1:WIDTH] << j));
            end
        end
        accNext = halvedReg ? {accHi, accLo} : accFull;
    end

    // Control, accumulator and result register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            product   <= '0;
            acc       <= '0;
            count     <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        acc   <= '0;
                        count <= '0;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    acc   <= accNext;
                    count <= count + 1'b1;
                    if (lastIter) begin
                        product   <= accNext;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Operand registers: loaded at accept, shifted while BUSY. They carry no
    // reset because nothing reads them outside a job.
    always_ff @(posedge clk) begin
        if (state == IDLE && in_valid) begin
            mcand     <= halved_precision
                         ? {extendLane(multiplicand[WIDTH-1:HALF], signed_mode),
                            extendLane(multiplicand[HALF-1:0], signed_mode)}
                         : extendFull(multiplicand, signed_mode);
            mplier    <= multiplier;
            signedReg <= signed_mode;
            halvedReg <= halved_precision;
        end else if (state == BUSY) begin
            mcand  <= halvedReg
                      ? {mcand[2*WIDTH-1:WIDTH] << BITS_PER_CYCLE,
                         mcand[WIDTH-1:0] << BITS_PER_CYCLE}
                      : (mcand << BITS_PER_CYCLE);
            mplier <= mplier >> BITS_PER_CYCLE;
        end
    end

endmodule

// File: tb/tb_seq_shiftadd_mult.sv
// ---------------------------------------------------------------------------
// tb_seq_shiftadd_mult
//
// Two instances: the default 8-bit / 1-bit-per-cycle multiplier and a
// 16-bit / 4-bits-per-cycle one. Accepted jobs are observed on the input
// handshake and their expected product and due cycle are queued; a monitor
// pops and compares whenever a new result is presented, and checks that a
// held result stays stable under backpressure.
// ---------------------------------------------------------------------------
module tb_seq_shiftadd_mult;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        inValid  [2];
    logic        inReady  [2];
    logic        outValid [2];
    logic        outReady [2];
    logic        sgnMode  [2];
    logic        halfMode [2];
    logic [15:0] opA      [2];
    logic [15:0] opB      [2];
    logic [15:0] prod8;
    logic [31:0] prod16;

    seq_shiftadd_mult #(.WIDTH(8), .BITS_PER_CYCLE(1)) dut8 (
        .clk              (clk),
        .rst              (rst),
        .in_valid         (inValid[0]),
        .in_ready         (inReady[0]),
        .multiplicand     (opA[0][7:0]),
        .multiplier       (opB[0][7:0]),
        .signed_mode      (sgnMode[0]),
        .halved_precision (halfMode[0]),
        .out_valid        (outValid[0]),
        .out_ready        (outReady[0]),
        .product          (prod8)
    );

    seq_shiftadd_mult #(.WIDTH(16), .BITS_PER_CYCLE(4)) dut16 (
        .clk              (clk),
        .rst              (rst),
        .in_valid         (inValid[1]),
        .in_ready         (inReady[1]),
        .multiplicand     (opA[1]),
        .multiplier       (opB[1]),
        .signed_mode      (sgnMode[1]),
        .halved_precision (halfMode[1]),
        .out_valid        (outValid[1]),
        .out_ready        (outReady[1]),
        .product          (prod16)
    );

    typedef struct {
        logic [31:0] prod;
        int          due;
    } expT;

    expT q0[$];
    expT q1[$];

    int nChecks = 0;
    int nFail   = 0;
    int cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Signed/unsigned lw x lw multiply, result modulo 2^(2*lw).
    function automatic logic [31:0] laneMul(input logic [15:0] a, input logic [15:0] b,
                                            input int lw, input bit sgn);
        longint mask;
        longint av;
        longint bv;
        longint r;
        mask = (longint'(1) << lw) - 1;
        av = longint'({48'h0, a}) & mask;
        bv = longint'({48'h0, b}) & mask;
        if (sgn && av[lw-1]) av = av - (longint'(1) << lw);
        if (sgn && bv[lw-1]) bv = bv - (longint'(1) << lw);
        r = av * bv;
        return 32'(r & ((longint'(1) << (2 * lw)) - 1));
    endfunction

    function automatic logic [31:0] refProduct(input int w, input logic [15:0] a,
                                               input logic [15:0] b, input bit sgn, input bit half);
        logic [31:0] lo;
        logic [31:0] hi;
        if (!half) return laneMul(a, b, w, sgn);
        lo = laneMul(a, b, w / 2, sgn);
        hi = laneMul(a >> (w / 2), b >> (w / 2), w / 2, sgn);
        return (hi << w) | lo;
    endfunction

    function automatic int latencyOf(input int k, input bit half);
        if (k == 0) return half ? 4 : 8;
        return half ? 2 : 4;
    endfunction

    // Scoreboard push on accept, pop/compare on each new result.
    bit          prevValid [2];
    logic [31:0] prevProd  [2];
    logic [31:0] monProd;
    expT         monE;

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            monProd = (k == 0) ? {16'h0, prod8} : prod16;
            if (rst) begin
                prevValid[k] = 1'b0;
            end else begin
                if (inValid[k] && inReady[k]) begin
                    monE.prod = refProduct((k == 0) ? 8 : 16, opA[k], opB[k], sgnMode[k], halfMode[k]);
                    monE.due  = cyc + 1 + latencyOf(k, halfMode[k]);
                    if (k == 0) q0.push_back(monE);
                    else        q1.push_back(monE);
                end
                if (outValid[k]) begin
                    if (!prevValid[k]) begin
                        if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
                            nChecks++;
                            nFail++;
                            $display("FAIL unexpectedResult dut%0d: product 0x%0h, expected no result", k, monProd);
                        end else begin
                            if (k == 0) monE = q0.pop_front();
                            else        monE = q1.pop_front();
                            check($sformatf("product dut%0d", k), monProd, monE.prod);
                            check($sformatf("latencyCycle dut%0d", k), 32'(cyc), 32'(monE.due));
                        end
                    end else begin
                        check($sformatf("holdStable dut%0d", k), monProd, prevProd[k]);
                    end
                    prevProd[k] = monProd;
                end
                prevValid[k] = outValid[k] && !outReady[k];
            end
        end
    end

    // Called just after a rising edge; returns just after the handshake edge.
    task automatic runJob(input int k, input logic [15:0] a, input logic [15:0] b,
                          input bit s, input bit h, input int hold);
        bit seen;
        opA[k]      = a;
        opB[k]      = b;
        sgnMode[k]  = s;
        halfMode[k] = h;
        inValid[k]  = 1'b1;
        outReady[k] = (hold == 0);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = inReady[k];
        end
        @(posedge clk);
        #1;
        inValid[k]  = 1'b0;
        opA[k]      = 16'($urandom);
        opB[k]      = 16'($urandom);
        sgnMode[k]  = 1'($urandom);
        halfMode[k] = 1'($urandom);
        check($sformatf("acceptSeen dut%0d", k), 32'(seen), 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            seen = outValid[k];
        end
        check($sformatf("resultSeen dut%0d", k), 32'(seen), 32'd1);
        if (hold > 0) begin
            repeat (hold) @(posedge clk);
            #1;
            outReady[k] = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit seen;
        for (int k = 0; k < 2; k++) begin
            inValid[k]  = 1'b0;
            outReady[k] = 1'b1;
            opA[k]      = '0;
            opB[k]      = '0;
            sgnMode[k]  = 1'b0;
            halfMode[k] = 1'b0;
        end

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rstInReady dut0", 32'(inReady[0]), 32'd0);
        check("rstInReady dut1", 32'(inReady[1]), 32'd0);
        check("rstOutValid dut0", 32'(outValid[0]), 32'd0);
        check("rstOutValid dut1", 32'(outValid[1]), 32'd0);
        check("rstProduct dut0", {16'h0, prod8}, 32'h0);
        check("rstProduct dut1", prod16, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("idleInReady dut0", 32'(inReady[0]), 32'd1);
        check("idleInReady dut1", 32'(inReady[1]), 32'd1);
        @(posedge clk);
        #1;

        // Directed corners, 8-bit instance
        runJob(0, 16'h00FD, 16'h0005, 1'b1, 1'b0, 0);
        runJob(0, 16'h00FF, 16'h00FF, 1'b0, 1'b0, 0);
        runJob(0, 16'h0080, 16'h0080, 1'b1, 1'b0, 0);
        runJob(0, 16'h0087, 16'h008F, 1'b1, 1'b1, 0);
        runJob(0, 16'h00FF, 16'h00FF, 1'b0, 1'b1, 0);

        // Backpressure with in_valid held high and operands changing
        opA[0] = 16'h0034; opB[0] = 16'h0056; sgnMode[0] = 1'b0; halfMode[0] = 1'b0;
        inValid[0] = 1'b1; outReady[0] = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = inReady[0];
        end
        @(posedge clk);
        #1;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            seen = outValid[0];
        end
        check("bpResultSeen", 32'(seen), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            opA[0] = 16'($urandom); opB[0] = 16'($urandom); sgnMode[0] = 1'($urandom);
            @(negedge clk);
            check("bpInReady", 32'(inReady[0]), 32'd0);
            check("bpOutValid", 32'(outValid[0]), 32'd1);
        end
        @(posedge clk);
        #1 outReady[0] = 1'b1;
        @(posedge clk);
        #1 inValid[0] = 1'b0;
        @(negedge clk);
        check("bpReleaseOutValid", 32'(outValid[0]), 32'd0);
        check("bpReleaseInReady", 32'(inReady[0]), 32'd1);
        @(posedge clk);
        #1;

        // Reset during the third BUSY cycle aborts the job
        opA[0] = 16'h0011; opB[0] = 16'h0013; sgnMode[0] = 1'b0; halfMode[0] = 1'b0;
        inValid[0] = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = inReady[0];
        end
        @(posedge clk);
        #1 inValid[0] = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        q0.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("abortOutValid", 32'(outValid[0]), 32'd0);
        check("abortProduct", {16'h0, prod8}, 32'h0);
        check("abortInReady", 32'(inReady[0]), 32'd1);
        @(posedge clk);
        #1;
        runJob(0, 16'h0002, 16'h0003, 1'b0, 1'b0, 0);

        // Randomized jobs on the 8-bit instance
        for (int i = 0; i < 40; i++)
            runJob(0, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 3));

        // Wider instance: corners, then randomized jobs
        runJob(1, 16'h8000, 16'h8000, 1'b1, 1'b0, 0);
        runJob(1, 16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 0);
        runJob(1, 16'h8080, 16'h80FF, 1'b1, 1'b1, 2);
        for (int i = 0; i < 60; i++)
            runJob(1, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 3));

        repeat (5) @(posedge clk);
        @(negedge clk);
        check("drainedQueue dut0", 32'(q0.size()), 32'd0);
        check("drainedQueue dut1", 32'(q1.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFail);
        $finish;
    end

endmodule
